vote_tally: RTL and testbench

Sequential, parametrised N-voter tally unit. It opens a voting session on `start` and latches at most one vote per voter. It closes the session when all voters have voted, when a timeout window expires, or optionally as soon as the outcome is decided. It then reports yes/no counts and a pass flag against a configurable threshold. It is the clocked successor to the team's fixed 5-input combinational majority voter and sits between the voter button/debounce logic and the result display.

---
 rtl/vote_pkg.sv | 15 +
 rtl/vote_popcount.sv | 20 ++
 rtl/vote_tally.sv | 116 +++++++++++
 tb/tb_vote_tally.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally unit.
// The session FSM states and the count width rule live here.
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      RESULT
   } vote_state_t;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of a W-bit vector.
// The result is wide enough to hold the value W itself.
module vote_popcount
   import vote_pkg::*;
#(
   parameter int W = 5,
   localparam int CW = cnt_width(W)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/vote_tally.sv
// N-voter tally: opens a session on start, latches one vote per voter,
// closes on all-voted, window timeout or (optionally) a decided outcome.
module vote_tally
   import vote_pkg::*;
#(
   parameter int N_VOTERS = 5,
   parameter int THRESH   = 3,
   parameter int WINDOW   = 16,
   parameter int EARLY    = 0,
   localparam int CW = cnt_width(N_VOTERS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N_VOTERS-1:0] vote_yes,
   input  logic [N_VOTERS-1:0] vote_no,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CW-1:0]       yes_count,
   output logic [CW-1:0]       no_count,
   output logic [N_VOTERS-1:0] voted
);

   // A one-cycle window still needs a one-bit timer.
   localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] THR       = CW'(THRESH);
   localparam logic [CW-1:0] NO_LIMIT  = CW'(N_VOTERS - THRESH);
   localparam logic [TW-1:0] LAST_TICK = TW'(WINDOW - 1);

   if (N_VOTERS < 1 || THRESH < 1 || THRESH > N_VOTERS || WINDOW < 1) begin : g_bad_params
      $error("vote_tally: illegal parameter combination");
   end

   vote_state_t         state_q, state_d;
   logic [TW-1:0]       timer_q;
   logic [N_VOTERS-1:0] voted_q, voted_d;
   logic [N_VOTERS-1:0] new_yes, new_no;
   logic [CW-1:0]       yes_q, no_q, yes_d, no_d;
   logic [CW-1:0]       add_yes, add_no;
   logic                pass_q;
   logic                early_hit, finish;

   // Conflicting or absent requests leave the voter eligible.
   assign new_yes = vote_yes & ~vote_no & ~voted_q;
   assign new_no  = vote_no & ~vote_yes & ~voted_q;

   vote_popcount #(.W(N_VOTERS)) u_pop_yes (
      .bits  (new_yes),
      .count (add_yes)
   );

   vote_popcount #(.W(N_VOTERS)) u_pop_no (
      .bits  (new_no),
      .count (add_no)
   );

   assign voted_d = voted_q | new_yes | new_no;
   assign yes_d   = yes_q + add_yes;
   assign no_d    = no_q + add_no;

   // Exit is judged on next-state values so the closing cycle's votes count.
   assign early_hit = (EARLY != 0) && ((yes_d >= THR) || (no_d > NO_LIMIT));
   assign finish    = (&voted_d) || (timer_q == LAST_TICK) || early_hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (finish) state_d = RESULT;
         RESULT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         voted_q <= '0;
         yes_q   <= '0;
         no_q    <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  timer_q <= '0;
                  voted_q <= '0;
                  yes_q   <= '0;
                  no_q    <= '0;
                  pass_q  <= 1'b0;
               end
            end
            COLLECT: begin
               timer_q <= timer_q + TW'(1);
               voted_q <= voted_d;
               yes_q   <= yes_d;
               no_q    <= no_d;
               if (finish) pass_q <= (yes_d >= THR);
            end
            default: begin
            end
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == RESULT);
   assign pass      = pass_q;
   assign yes_count = yes_q;
   assign no_count  = no_q;
   assign voted     = voted_q;

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: table vectors, random sessions against a
// high-level model, plus hand sequences for reset, restart and a 1-voter build.
module tb_vote_tally;

   localparam int N   = 5;
   localparam int THR = 3;
   localparam int WIN = 8;
   localparam logic [4:0] Z = 5'd0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start;
   logic [4:0] vote_yes, vote_no;

   logic       busy_m, done_m, pass_m;
   logic [2:0] yes_m, no_m;
   logic [4:0] voted_m;
   logic       busy_e, done_e, pass_e;
   logic [2:0] yes_e, no_e;
   logic [4:0] voted_e;

   logic       start_t;
   logic [0:0] vy_t, vn_t, yes_t, no_t, voted_t;
   logic       busy_t, done_t, pass_t;

   vote_tally #(.N_VOTERS(N), .THRESH(THR), .WINDOW(WIN), .EARLY(0)) dut_main (
      .clk(clk), .rst(rst), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
      .busy(busy_m), .done(done_m), .pass(pass_m), .yes_count(yes_m),
      .no_count(no_m), .voted(voted_m)
   );

   vote_tally #(.N_VOTERS(N), .THRESH(THR), .WINDOW(WIN), .EARLY(1)) dut_early (
      .clk(clk), .rst(rst), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
      .busy(busy_e), .done(done_e), .pass(pass_e), .yes_count(yes_e),
      .no_count(no_e), .voted(voted_e)
   );

   vote_tally #(.N_VOTERS(1), .THRESH(1), .WINDOW(4), .EARLY(0)) dut_tiny (
      .clk(clk), .rst(rst), .start(start_t), .vote_yes(vy_t), .vote_no(vn_t),
      .busy(busy_t), .done(done_t), .pass(pass_t), .yes_count(yes_t),
      .no_count(no_t), .voted(voted_t)
   );

   typedef struct {
      int done_at;
      int yes;
      int no;
      int pass;
      int voted;
   } res_t;

   typedef struct {
      string      name;
      logic [39:0] ys;
      logic [39:0] ns;
      bit         start_mid;
      int         dm;
      int         de;
      int         yes;
      int         no;
      int         pass;
      int         voted;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [39:0] seq5(input logic [4:0] c0, c1, c2, c3, c4);
      return {15'd0, c4, c3, c2, c1, c0};
   endfunction

   // Reference: walk the session cycle by cycle over plain integer counts.
   function automatic res_t model(input logic [39:0] ys, input logic [39:0] ns, input bit early);
      res_t       r;
      logic [4:0] v;
      int         y, n;
      v = '0;
      y = 0;
      n = 0;
      r.done_at = -1;
      for (int c = 0; c < WIN; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i] && ys[c*N+i] != ns[c*N+i]) begin
               v[i] = 1'b1;
               if (ys[c*N+i]) y++;
               else n++;
            end
         end
         if ($countones(v) == N || (early && (y >= THR || n > N - THR)) || c == WIN - 1) begin
            r.done_at = c + 2;
            break;
         end
      end
      r.yes   = y;
      r.no    = n;
      r.pass  = (y >= THR) ? 1 : 0;
      r.voted = int'(v);
      return r;
   endfunction

   task automatic applyStimulus(input logic [39:0] ys, input logic [39:0] ns, input bit start_mid,
                                output res_t rm, output res_t re, output int busy_bad);
      bit gm, ge;
      gm = 0;
      ge = 0;
      rm = '{-1, 0, 0, 0, 0};
      re = '{-1, 0, 0, 0, 0};
      busy_bad = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (!gm && done_m) begin
            gm = 1;
            rm.done_at = c;
            rm.yes = int'(yes_m);
            rm.no = int'(no_m);
            rm.pass = int'(pass_m);
            rm.voted = int'(voted_m);
         end
         if (!ge && done_e) begin
            ge = 1;
            re.done_at = c;
            re.yes = int'(yes_e);
            re.no = int'(no_e);
            re.pass = int'(pass_e);
            re.voted = int'(voted_e);
         end
         if (!gm && !busy_m) busy_bad++;
         if (gm && ge) break;
         vote_yes = (c <= WIN) ? ys[(c-1)*N +: N] : Z;
         vote_no  = (c <= WIN) ? ns[(c-1)*N +: N] : Z;
         start    = start_mid && (c == 3);
         step();
      end
      vote_yes = '0;
      vote_no  = '0;
      start    = 1'b0;
      step();
   endtask

   task automatic checkSession(input string name, input res_t got, input res_t exp);
      checkOutput({name, ".done_at"}, got.done_at, exp.done_at);
      checkOutput({name, ".yes"}, got.yes, exp.yes);
      checkOutput({name, ".no"}, got.no, exp.no);
      checkOutput({name, ".pass"}, got.pass, exp.pass);
      checkOutput({name, ".voted"}, got.voted, exp.voted);
   endtask

   vec_t tbl[9];

   initial begin
      res_t rm, re, em, ee;
      int   bb, seen, dat;

      tbl[0] = '{"unanimous", seq5(5'b00111, Z, Z, Z, Z), seq5(5'b11000, Z, Z, Z, Z), 0, 2, 2, 3, 2, 1, 5'b11111};
      tbl[1] = '{"timeout", seq5(5'b00011, Z, Z, Z, Z), seq5(Z, Z, Z, Z, Z), 0, 9, 9, 2, 0, 0, 5'b00011};
      tbl[2] = '{"early_yes", seq5(5'b00111, Z, Z, Z, Z), seq5(Z, Z, Z, Z, Z), 0, 9, 2, 3, 0, 1, 5'b00111};
      tbl[3] = '{"early_no", seq5(Z, Z, Z, Z, Z), seq5(5'b00111, Z, Z, Z, Z), 0, 9, 2, 0, 3, 0, 5'b00111};
      tbl[4] = '{"revote", seq5(5'b00101, Z, Z, Z, Z), seq5(5'b00100, 5'b00100, 5'b00001, Z, Z), 0, 9, 9, 1, 1, 0, 5'b00101};
      tbl[5] = '{"all_no", seq5(Z, Z, Z, Z, Z), seq5(5'b11111, Z, Z, Z, Z), 0, 2, 2, 0, 5, 0, 5'b11111};
      tbl[6] = '{"spread", seq5(5'b00001, 5'b00010, Z, Z, 5'b10000), seq5(Z, Z, 5'b00100, 5'b01000, Z), 0, 6, 6, 3, 2, 1, 5'b11111};
      tbl[7] = '{"early_mid", seq5(5'b00011, Z, 5'b00100, Z, Z), seq5(Z, Z, Z, Z, Z), 0, 9, 4, 3, 0, 1, 5'b00111};
      tbl[8] = '{"ignored_start", seq5(5'b00011, Z, Z, Z, Z), seq5(Z, Z, Z, Z, Z), 1, 9, 9, 2, 0, 0, 5'b00011};

      rst = 1'b1;
      start = 1'b0;
      vote_yes = '0;
      vote_no = '0;
      start_t = 1'b0;
      vy_t = '0;
      vn_t = '0;
      repeat (3) step();
      checkOutput("reset.busy", int'(busy_m), 0);
      checkOutput("reset.done", int'(done_m), 0);
      checkOutput("reset.pass", int'(pass_m), 0);
      checkOutput("reset.yes", int'(yes_m), 0);
      checkOutput("reset.no", int'(no_m), 0);
      checkOutput("reset.voted", int'(voted_m), 0);
      rst = 1'b0;
      step();

      // Back-to-back sessions: each start lands in the cycle right after done.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(tbl[i].ys, tbl[i].ns, tbl[i].start_mid, rm, re, bb);
         em = '{tbl[i].dm, tbl[i].yes, tbl[i].no, tbl[i].pass, tbl[i].voted};
         ee = '{tbl[i].de, tbl[i].yes, tbl[i].no, tbl[i].pass, tbl[i].voted};
         checkSession({tbl[i].name, ".main"}, rm, em);
         checkSession({tbl[i].name, ".early"}, re, ee);
         checkOutput({tbl[i].name, ".busy_gap"}, bb, 0);
         checkOutput({tbl[i].name, ".idle_busy"}, int'(busy_m), 0);
         checkOutput({tbl[i].name, ".held_yes"}, int'(yes_m), tbl[i].yes);
         checkOutput({tbl[i].name, ".held_pass"}, int'(pass_m), tbl[i].pass);
      end

      for (int k = 0; k < 40; k++) begin
         logic [39:0] ys, ns;
         ys = {$urandom, $urandom} & {$urandom, $urandom};
         ns = {$urandom, $urandom} & {$urandom, $urandom};
         if (k % 4 == 0) ns = ns & ~ys;
         em = model(ys, ns, 1'b0);
         ee = model(ys, ns, 1'b1);
         applyStimulus(ys, ns, 1'b0, rm, re, bb);
         checkSession("rand.main", rm, em);
         checkSession("rand.early", re, ee);
         checkOutput("rand.busy_gap", bb, 0);
      end

      // Reset in cycle t+3 aborts the session without a done pulse.
      start = 1'b1;
      step();
      start = 1'b0;
      vote_yes = 5'b00001;
      step();
      vote_yes = '0;
      step();
      rst = 1'b1;
      step();
      checkOutput("midreset.busy", int'(busy_m), 0);
      checkOutput("midreset.done", int'(done_m), 0);
      checkOutput("midreset.yes", int'(yes_m), 0);
      checkOutput("midreset.voted", int'(voted_m), 0);
      checkOutput("midreset.busy_early", int'(busy_e), 0);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (done_m || done_e) seen++;
         step();
      end
      checkOutput("midreset.no_done", seen, 0);

      // Single-voter build: immediate yes, then a conflicting vote that times out.
      start_t = 1'b1;
      step();
      start_t = 1'b0;
      vy_t = 1'b1;
      step();
      vy_t = 1'b0;
      checkOutput("tiny.done", int'(done_t), 1);
      checkOutput("tiny.pass", int'(pass_t), 1);
      checkOutput("tiny.yes", int'(yes_t), 1);
      checkOutput("tiny.voted", int'(voted_t), 1);
      step();
      checkOutput("tiny.idle", int'(busy_t), 0);

      start_t = 1'b1;
      step();
      start_t = 1'b0;
      dat = -1;
      for (int c = 1; c <= 12; c++) begin
         if (done_t) begin
            dat = c;
            break;
         end
         vy_t = (c == 1);
         vn_t = (c == 1);
         step();
      end
      vy_t = 1'b0;
      vn_t = 1'b0;
      checkOutput("tiny_timeout.done_at", dat, 5);
      checkOutput("tiny_timeout.pass", int'(pass_t), 0);
      checkOutput("tiny_timeout.voted", int'(voted_t), 0);
      checkOutput("tiny_timeout.yes", int'(yes_t), 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
